// File: rtl/mini_datapath_seq.sv
// Two-state instruction sequencer: latches operands from a 4-entry register file,
// drives a mini_datapath for one execute cycle, then writes the result back.
module mini_datapath_seq #(
   parameter int WIDTH = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_instr_valid,
   output logic               o_instr_ready,
   input  logic [WIDTH+7:0]   i_instr,
   input  logic               i_init_we,
   input  logic [1:0]         i_init_addr,
   input  logic [WIDTH-1:0]   i_init_data,
   input  logic [1:0]         i_dbg_addr,
   output logic [WIDTH-1:0]   o_dbg_data,
   output logic [WIDTH-1:0]   o_alu_in_a,
   output logic [WIDTH-1:0]   o_reg_data,
   output logic [WIDTH-1:0]   o_immediate_data,
   output logic [2:0]         o_alu_sel,
   output logic               o_mux_sel,
   input  logic [WIDTH-1:0]   i_result,
   input  logic               i_carry_out,
   output logic               o_done,
   output logic [WIDTH-1:0]   o_wb_data,
   output logic               o_carry_flag
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_rf [4];
   logic [1:0]       r_rd;
   logic             r_instr_ready;
   logic             r_done;
   logic [WIDTH-1:0] r_wb_data;
   logic             r_carry_flag;
   logic [WIDTH-1:0] r_alu_in_a;
   logic [WIDTH-1:0] r_reg_data;
   logic [WIDTH-1:0] r_immediate_data;
   logic [2:0]       r_alu_sel;
   logic             r_mux_sel;

   logic [2:0]       w_op;
   logic             w_imm_sel;
   logic [1:0]       w_rd;
   logic [1:0]       w_rs1;
   logic [1:0]       w_rs2;
   logic [WIDTH-1:0] w_imm;

   assign w_op      = i_instr[WIDTH+7:WIDTH+5];
   assign w_imm_sel = i_instr[WIDTH+4];
   assign w_rd      = i_instr[WIDTH+3:WIDTH+2];
   assign w_rs1     = i_instr[WIDTH+1:WIDTH];
   assign w_imm     = i_instr[WIDTH-1:0];
   assign w_rs2     = i_instr[1:0];

   // Sequencer FSM, register file and all registered outputs; reset overrides everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state          <= ST_IDLE;
         r_rf[0]          <= {WIDTH{1'b0}};
         r_rf[1]          <= {WIDTH{1'b0}};
         r_rf[2]          <= {WIDTH{1'b0}};
         r_rf[3]          <= {WIDTH{1'b0}};
         r_rd             <= 2'b00;
         r_instr_ready    <= 1'b1;
         r_done           <= 1'b0;
         r_wb_data        <= {WIDTH{1'b0}};
         r_carry_flag     <= 1'b0;
         r_alu_in_a       <= {WIDTH{1'b0}};
         r_reg_data       <= {WIDTH{1'b0}};
         r_immediate_data <= {WIDTH{1'b0}};
         r_alu_sel        <= 3'b000;
         r_mux_sel        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               if (i_init_we) begin
                  r_rf[i_init_addr] <= i_init_data;
               end
               // Operands sample the pre-edge file, so a same-edge init is not seen.
               if (i_instr_valid) begin
                  r_alu_sel        <= w_op;
                  r_mux_sel        <= w_imm_sel;
                  r_immediate_data <= w_imm;
                  r_alu_in_a       <= r_rf[w_rs1];
                  r_reg_data       <= r_rf[w_rs2];
                  r_rd             <= w_rd;
                  r_instr_ready    <= 1'b0;
                  r_state          <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_rf[r_rd]    <= i_result;
               r_wb_data     <= i_result;
               r_carry_flag  <= i_carry_out;
               r_done        <= 1'b1;
               r_instr_ready <= 1'b1;
               r_state       <= ST_IDLE;
            end
            default: begin
               r_done        <= 1'b0;
               r_instr_ready <= 1'b1;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_instr_ready    = r_instr_ready;
   assign o_done           = r_done;
   assign o_wb_data        = r_wb_data;
   assign o_carry_flag     = r_carry_flag;
   assign o_alu_in_a       = r_alu_in_a;
   assign o_reg_data       = r_reg_data;
   assign o_immediate_data = r_immediate_data;
   assign o_alu_sel        = r_alu_sel;
   assign o_mux_sel        = r_mux_sel;
   assign o_dbg_data       = r_rf[i_dbg_addr];

endmodule

// File: doc/mini_datapath_seq.md
# mini_datapath_seq

Instruction sequencer that drives the `mini_datapath` operand/control inputs and consumes its `result`/`carry_out`. It holds a 4-entry register file, accepts one instruction per valid/ready handshake, and presents operands and the ALU select to the datapath for one execute cycle. It then writes the returned result back into the register file and latches a carry flag. It sits between an instruction source (bench or future fetch unit) and a `mini_datapath` instance.

## Interface
- `WIDTH`, 8, datapath word width; instruction width is `WIDTH+8`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  sequencer can accept; high only in IDLE.
- `instr`  in  WIDTH+8  fields:
  - [WIDTH+7:WIDTH+5] op
  - [WIDTH+4] imm_sel
  - [WIDTH+3:WIDTH+2] rd
  - [WIDTH+1:WIDTH] rs1
  - [WIDTH-1:0] imm; rs2 = imm[1:0]
- `init_we`, `init_addr[1:0]`, `init_data[WIDTH-1:0]`  in  register preload port.
- `dbg_addr`  in  2  debug read address.
- `dbg_data`  out  WIDTH  combinational rf[dbg_addr].
- `alu_in_a`  out  WIDTH  to datapath operand A.
- `reg_data`  out  WIDTH  to datapath register operand.
- `immediate_data`  out  WIDTH  to datapath immediate.
- `alu_sel`  out  3  to datapath ALU select.
- `mux_sel`  out  1  to datapath; 1 selects immediate.
- `result`  in  WIDTH  from datapath.
- `carry_out`  in  1  from datapath.
- `done`  out  1  one-cycle pulse: writeback occurred.
- `wb_data`  out  WIDTH  value written by the last writeback.
- `carry_flag`  out  1  carry captured at the last writeback.

## Operation
- States: IDLE, EXEC.
- IDLE → EXEC on `instr_valid && instr_ready`. At that edge, latch:
  - `alu_sel` ← op
  - `mux_sel` ← imm_sel
  - `immediate_data` ← imm
  - `alu_in_a` ← rf[rs1]
  - `reg_data` ← rf[rs2]
  - rd
- Operands are read from rf values before any same-edge write.
- EXEC → IDLE unconditionally after one cycle. At that edge:
  - rf[rd] ← `result`
  - `carry_flag` ← `carry_out`
  - `wb_data` ← `result`
  - `done` ← 1
- `done` is high for exactly the first IDLE cycle after EXEC, otherwise 0.
- Datapath-facing outputs are registered and hold their value until the next accept. `alu_sel`/`mux_sel` are pure pass-through; the sequencer never interprets op.
- `init_we` writes rf[init_addr] ← init_data only in IDLE; it is ignored in EXEC.
  - Accept and init in the same IDLE cycle: both take effect. The accepted instruction sees the old value.
- `rd` may equal `rs1`/`rs2`; the read happens at accept and the write at EXEC end, so there is no hazard.
- `instr_valid` in EXEC is ignored (ready low). The source must hold the instruction until the handshake completes.
- Reset values:
  - state IDLE
  - rf all 0
  - every output 0 except `instr_ready` = 1 and `dbg_data` = rf[dbg_addr] = 0

## Timing
- Edge E0: accept. Cycle E0–E1: EXEC; datapath inputs stable the whole cycle. `result` must settle combinationally within this cycle.
- Edge E1: writeback; `done` = 1 and `instr_ready` = 1 during E1–E2.
- A new instruction may be accepted at E2, so the next instruction reads the written value. Peak throughput is 1 instruction / 2 cycles.
- `dbg_data` reflects a writeback in the cycle after the write edge.
- `rst` asserted in EXEC: no writeback, `done` stays 0, rf cleared, state IDLE at the next edge.
- `rst` has priority over accept, init, and writeback in the same edge.

## Test plan
Bench wraps the sequencer with `mini_datapath` and a behavioural ALU: op 000 = A+B with carry, 001 = A−B.
- Reset → `instr_ready`=1, `done`=0, all datapath outputs 0, rf[0..3]=0 via `dbg_data`.
- init rf[1]=0x10; instr op=000, imm_sel=1, rd=2, rs1=1, imm=0x05 → EXEC shows `alu_in_a`=0x10, `immediate_data`=0x05, `mux_sel`=1. Next cycle `done`=1, `wb_data`=0x15, rf[2]=0x15, `carry_flag`=0.
- rf[0]=0xF0, rf[3]=0x20; op=000, imm_sel=0, rd=0, rs1=0, rs2=3 → `wb_data`=0x10, `carry_flag`=1, rf[0]=0x10.
- Back-to-back: instr_valid held high with two dependent instructions (second uses rd of first) → second accepted exactly 2 cycles after the first and reads the updated value; `instr_ready`=0 during each EXEC.
- `rst` pulsed during EXEC of op=000 rd=1 → no `done`, rf[1]=0, `instr_ready`=1 the cycle after reset.
- init_we to rf[1] during EXEC → rf[1] unchanged. init_we concurrent with accept reading rf[1] → operand uses the old value, and rf[1] gets init_data (unless rd=1).
